// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Writeback arbiter for the register file write port, with a busy scoreboard.
// Two requesters (A = ALU result, B = load data) share the single write port
// using a round-robin tie break. The port is driven from registers, so a
// transfer on edge N shows up on rf_we/rf_rd/rf_data from edge N for exactly
// one cycle. The scoreboard tracks issued-but-unwritten destinations so that
// decode can stall on RS/RT hazards.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   a_valid/a_addr/a_data    requester A write request
//   a_ready                  A granted this cycle (combinational)
//   b_valid/b_addr/b_data    requester B write request
//   b_ready                  B granted this cycle (combinational)
//   hold                     suppresses all grants while high
//   iss_valid/iss_rd         decode issues a write to iss_rd (marks it busy)
//   q_rs/q_rt                hazard query registers
//   haz_rs/haz_rt            busy state of q_rs/q_rt (combinational)
//   busy_vec                 scoreboard contents, bit 0 always 0
//   rf_we/rf_rd/rf_data      register file write port (registered)
module regfile_wb_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    input  logic [AW-1:0]        a_addr,
    input  logic [DW-1:0]        a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [AW-1:0]        b_addr,
    input  logic [DW-1:0]        b_data,
    output logic                 b_ready,
    input  logic                 hold,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic [AW-1:0]        q_rs,
    input  logic [AW-1:0]        q_rt,
    output logic                 haz_rs,
    output logic                 haz_rt,
    output logic [(1<<AW)-1:0]   busy_vec,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_rd,
    output logic [DW-1:0]        rf_data
);

    localparam int NREG = 1 << AW;

    // 1 = A was granted most recently. Resets to "B last" so A wins the
    // first tie.
    logic            last_a_reg;
    logic            a_xfer;
    logic            b_xfer;
    logic            xfer;
    logic [AW-1:0]   xfer_addr;
    logic [DW-1:0]   xfer_data;
    logic [NREG-1:1] busy_reg;

    // Grants are gated by rst_n so that asserting reset drops a pending
    // grant immediately, not just at the next edge.
    assign a_ready = rst_n & ~hold & a_valid & (~b_valid | ~last_a_reg);
    assign b_ready = rst_n & ~hold & b_valid & (~a_valid |  last_a_reg);

    assign a_xfer    = a_valid & a_ready;
    assign b_xfer    = b_valid & b_ready;
    assign xfer      = a_xfer | b_xfer;
    assign xfer_addr = a_xfer ? a_addr : b_addr;
    assign xfer_data = a_xfer ? a_data : b_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we      <= 1'b0;
            rf_rd      <= '0;
            rf_data    <= '0;
            last_a_reg <= 1'b0;
        end else if (xfer) begin
            // Writes to register 0 are acknowledged but never enabled.
            rf_we      <= (xfer_addr != '0);
            rf_rd      <= xfer_addr;
            rf_data    <= xfer_data;
            last_a_reg <= a_xfer;
        end else begin
            rf_we      <= 1'b0;
        end
    end

    // One scoreboard bit per register 1..NREG-1; register 0 is never busy.
    // A same-edge issue beats a completing write to the same register,
    // because the issue represents a newer outstanding write.
    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
            logic set_bit;
            logic clr_bit;
            assign set_bit = iss_valid & (iss_rd == AW'(gi));
            assign clr_bit = xfer & (xfer_addr == AW'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    busy_reg[gi] <= 1'b0;
                end else if (set_bit) begin
                    busy_reg[gi] <= 1'b1;
                end else if (clr_bit) begin
                    busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign busy_vec = {busy_reg, 1'b0};

    // Plain read of the current scoreboard; no bypass of same-cycle
    // issue/clear. Bit 0 is constant 0, so queries of register 0 never hit.
    assign haz_rs = busy_vec[q_rs];
    assign haz_rt = busy_vec[q_rt];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter. Each scenario task drives stimulus,
// pushes the expected register-file write onto a scoreboard queue when it
// grants, and pops/compares once the registered write port updates.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, hold, iss_valid;
    logic [4:0]  a_addr, b_addr, iss_rd, q_rs, q_rt;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, haz_rs, haz_rt, rf_we;
    logic [31:0] busy_vec;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         e;
    logic [31:0] exp_busy;
    int          n_checks = 0;
    int          n_fail   = 0;

    regfile_wb_arbiter #(.AW(5), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .hold(hold), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .q_rs(q_rs), .q_rt(q_rt), .haz_rs(haz_rs), .haz_rt(haz_rt),
        .busy_vec(busy_vec), .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; hold = 1'b0;
        iss_valid = 1'b0; a_addr = 5'd1; b_addr = 5'd2; a_data = '0; b_data = '0;
        iss_rd = '0; q_rs = '0; q_rt = '0;
        exp_busy = '0;
        tick(); tick();
        n_checks++;
        if ({a_ready, b_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got a=%0b b=%0b want 0 0", a_ready, b_ready);
        end
        n_checks++;
        if ({rf_we, rf_rd, rf_data, busy_vec} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got we=%0b rd=%0d data=%h busy=%h want all 0",
                               rf_we, rf_rd, rf_data, busy_vec);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        $display("reset: done");
    endtask

    task automatic test_single_a();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hAAAA_0001;
        #1;
        n_checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            n_fail++; $display("FAIL single_a_ready: got a=%0b b=%0b want 1 0", a_ready, b_ready);
        end
        exp_q.push_back('{1'b1, 5'd5, 32'hAAAA_0001});
        tick();
        a_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if ({rf_we, rf_rd, rf_data} !== {e.we, e.rd, e.data}) begin
            n_fail++; $display("FAIL single_a_write: got we=%0b rd=%0d data=%h want we=%0b rd=%0d data=%h",
                               rf_we, rf_rd, rf_data, e.we, e.rd, e.data);
        end
        tick();
        n_checks++;
        if ({rf_we, rf_rd, rf_data} !== {1'b0, 5'd5, 32'hAAAA_0001}) begin
            n_fail++; $display("FAIL single_a_idle: got we=%0b rd=%0d data=%h want we=0 rd=5 data=aaaa0001",
                               rf_we, rf_rd, rf_data);
        end
        $display("single_a: write rd=5 data=aaaa0001");
    endtask

    task automatic test_back_to_back();
        bit exp_a;
        // A single B write makes B the most recent grant, so the next tie goes to A.
        b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h0000_0B06;
        #1;
        n_checks++;
        if ({a_ready, b_ready} !== 2'b01) begin
            n_fail++; $display("FAIL single_b_ready: got a=%0b b=%0b want 0 1", a_ready, b_ready);
        end
        exp_q.push_back('{1'b1, 5'd6, 32'h0000_0B06});
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if ({rf_we, rf_rd, rf_data} !== {e.we, e.rd, e.data}) begin
            n_fail++; $display("FAIL single_b_write: got we=%0b rd=%0d data=%h want rd=%0d data=%h",
                               rf_we, rf_rd, rf_data, e.rd, e.data);
        end
        a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h1010_1010;
        b_valid = 1'b1; b_addr = 5'd11; b_data = 32'h2020_2020;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            #1;
            n_checks++;
            if ({a_ready, b_ready} !== {exp_a, !exp_a}) begin
                n_fail++; $display("FAIL b2b_grant%0d: got a=%0b b=%0b want a=%0b b=%0b",
                                   i, a_ready, b_ready, exp_a, !exp_a);
            end
            if (exp_a) exp_q.push_back('{1'b1, 5'd10, 32'h1010_1010});
            else       exp_q.push_back('{1'b1, 5'd11, 32'h2020_2020});
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({rf_we, rf_rd, rf_data} !== {e.we, e.rd, e.data}) begin
                n_fail++; $display("FAIL b2b_write%0d: got we=%0b rd=%0d data=%h want we=%0b rd=%0d data=%h",
                                   i, rf_we, rf_rd, rf_data, e.we, e.rd, e.data);
            end
            $display("b2b: cycle %0d grant %s rd=%0d", i, exp_a ? "A" : "B", e.rd);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_rd = 5'd7; q_rs = 5'd7;
        #1;
        // No bypass of a same-cycle issue.
        n_checks++;
        if (haz_rs !== 1'b0) begin
            n_fail++; $display("FAIL haz_no_bypass: got haz_rs=%0b want 0", haz_rs);
        end
        tick();
        iss_valid = 1'b0;
        exp_busy[7] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (haz_rs !== 1'b1 || busy_vec !== exp_busy) begin
                n_fail++; $display("FAIL haz_set%0d: got haz_rs=%0b busy=%h want 1 busy=%h",
                                   i, haz_rs, busy_vec, exp_busy);
            end
            tick();
        end
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h7777_0007;
        #1;
        exp_q.push_back('{1'b1, 5'd7, 32'h7777_0007});
        n_checks++;
        if (haz_rs !== 1'b1 || a_ready !== 1'b1) begin
            n_fail++; $display("FAIL haz_pre_clear: got haz_rs=%0b a_ready=%0b want 1 1", haz_rs, a_ready);
        end
        tick();
        a_valid = 1'b0;
        exp_busy[7] = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (haz_rs !== 1'b0 || busy_vec !== exp_busy || {rf_we, rf_rd, rf_data} !== {e.we, e.rd, e.data}) begin
            n_fail++; $display("FAIL haz_clear: got haz_rs=%0b busy=%h we=%0b rd=%0d want 0 busy=%h we=1 rd=7",
                               haz_rs, busy_vec, rf_we, rf_rd, exp_busy);
        end
        $display("scoreboard: reg 7 set then cleared by write");
    endtask

    task automatic test_same_edge();
        // Issue and transfer to the same register: set wins.
        iss_valid = 1'b1; iss_rd = 5'd9;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0000_0009;
        exp_q.push_back('{1'b1, 5'd9, 32'h0000_0009});
        tick();
        exp_busy[9] = 1'b1;
        e = exp_q.pop_front();
        n_checks++;
        if (busy_vec !== exp_busy || {rf_we, rf_rd, rf_data} !== {e.we, e.rd, e.data}) begin
            n_fail++; $display("FAIL same_reg_edge: got busy=%h we=%0b rd=%0d want busy=%h we=1 rd=9",
                               busy_vec, rf_we, rf_rd, exp_busy);
        end
        a_valid = 1'b0; iss_rd = 5'd4;
        tick();
        exp_busy[4] = 1'b1;
        // Issue to 3 and B transfer to 4 on the same edge: both apply.
        iss_rd = 5'd3;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h0000_0004;
        exp_q.push_back('{1'b1, 5'd4, 32'h0000_0004});
        tick();
        iss_valid = 1'b0; b_valid = 1'b0;
        exp_busy[3] = 1'b1; exp_busy[4] = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (busy_vec !== exp_busy || {rf_we, rf_rd, rf_data} !== {e.we, e.rd, e.data}) begin
            n_fail++; $display("FAIL diff_reg_edge: got busy=%h we=%0b rd=%0d want busy=%h we=1 rd=4",
                               busy_vec, rf_we, rf_rd, exp_busy);
        end
        $display("same_edge: busy=%h", busy_vec);
    endtask

    task automatic test_reg0();
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF;
        iss_valid = 1'b1; iss_rd = 5'd0;
        q_rs = 5'd0; q_rt = 5'd9;
        #1;
        n_checks++;
        if (a_ready !== 1'b1 || haz_rs !== 1'b0 || haz_rt !== 1'b1) begin
            n_fail++; $display("FAIL reg0_ready_haz: got a_ready=%0b haz_rs=%0b haz_rt=%0b want 1 0 1",
                               a_ready, haz_rs, haz_rt);
        end
        exp_q.push_back('{1'b0, 5'd0, 32'hFFFF_FFFF});
        tick();
        a_valid = 1'b0; iss_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if ({rf_we, rf_rd, rf_data} !== {e.we, e.rd, e.data} || busy_vec !== exp_busy) begin
            n_fail++; $display("FAIL reg0_write: got we=%0b rd=%0d data=%h busy=%h want we=0 rd=0 data=ffffffff busy=%h",
                               rf_we, rf_rd, rf_data, busy_vec, exp_busy);
        end
        $display("reg0: write acknowledged, no enable");
    endtask

    task automatic test_hold_reset();
        hold = 1'b1;
        a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hC0C0_0012;
        b_valid = 1'b1; b_addr = 5'd13; b_data = 32'hD0D0_0013;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({a_ready, b_ready} !== 2'b00) begin
                n_fail++; $display("FAIL hold_ready%0d: got a=%0b b=%0b want 0 0", i, a_ready, b_ready);
            end
            tick();
            n_checks++;
            if (rf_we !== 1'b0) begin
                n_fail++; $display("FAIL hold_we%0d: got rf_we=%0b want 0", i, rf_we);
            end
        end
        hold = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_busy = '0;
        n_checks++;
        if ({a_ready, b_ready, rf_we, rf_rd, rf_data, busy_vec} !== '0) begin
            n_fail++; $display("FAIL midreset: got a=%0b b=%0b we=%0b rd=%0d data=%h busy=%h want all 0",
                               a_ready, b_ready, rf_we, rf_rd, rf_data, busy_vec);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            n_fail++; $display("FAIL post_reset_grant: got a=%0b b=%0b want 1 0", a_ready, b_ready);
        end
        exp_q.push_back('{1'b1, 5'd12, 32'hC0C0_0012});
        tick();
        a_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if ({rf_we, rf_rd, rf_data} !== {e.we, e.rd, e.data} || b_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_write: got we=%0b rd=%0d data=%h b_ready=%0b want we=1 rd=12 data=c0c00012 b_ready=1",
                               rf_we, rf_rd, rf_data, b_ready);
        end
        exp_q.push_back('{1'b1, 5'd13, 32'hD0D0_0013});
        tick();
        b_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if ({rf_we, rf_rd, rf_data} !== {e.we, e.rd, e.data}) begin
            n_fail++; $display("FAIL post_reset_b: got we=%0b rd=%0d data=%h want we=1 rd=13 data=d0d00013",
                               rf_we, rf_rd, rf_data);
        end
        $display("hold_reset: A first after reset, then B");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_a();
        test_back_to_back();
        test_scoreboard();
        test_same_edge();
        test_reg0();
        test_hold_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
